// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: bus commands, tag width and requester ownership.
package mem_arbiter_pkg;
  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } ARB_OWNER;
endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table: one allocate port and one lookup/free port.
// Macro TEST_MODE adds show_valid_o/show_owner_o observation ports.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en_i,
  input  logic [MEM_TAG_W-1:0] alloc_tag_i,
  input  ARB_OWNER             alloc_owner_i,
  input  logic [MEM_TAG_W-1:0] lookup_tag_i,
  output logic                 lookup_hit_o,
  output ARB_OWNER             lookup_owner_o
`ifdef TEST_MODE
  ,
  output logic [NUM_TAGS-1:0]  show_valid_o,
  output logic [NUM_TAGS-1:0]  show_owner_o
`endif
);
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;

  // Tag 0 never names a transaction, so it can never hit.
  assign lookup_hit_o   = (lookup_tag_i != MEM_TAG_W'(0)) && valid_q[lookup_tag_i];
  assign lookup_owner_o = ARB_OWNER'(owner_q[lookup_tag_i]);

  // Retire on a hit first, then allocate, so a same-cycle reuse of a tag stays valid.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (lookup_hit_o) begin
      valid_d[lookup_tag_i] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (alloc_en_i) begin
      valid_d[alloc_tag_i] = 1'b1;
      owner_d[alloc_tag_i] = alloc_owner_i;
    end else begin
      owner_d = owner_q;
    end
  end

  // Table state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= {NUM_TAGS{1'b0}};
      owner_q <= {NUM_TAGS{1'b0}};
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

`ifdef TEST_MODE
  assign show_valid_o = valid_q;
  assign show_owner_o = owner_q;
`endif

  mem_tag_table_chk #(.NUM_TAGS(NUM_TAGS)) u_chk (
    .clock       (clock),
    .reset       (reset),
    .alloc_en_i  (alloc_en_i),
    .alloc_tag_i (alloc_tag_i),
    .free_en_i   (lookup_hit_o),
    .free_tag_i  (lookup_tag_i),
    .valid_i     (valid_q)
  );
endmodule

// File: rtl/mem_tag_table_chk.sv
// Simulation checker for mem_tag_table: memory must not hand out a tag that is still outstanding.
module mem_tag_table_chk
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input logic                 clock,
  input logic                 reset,
  input logic                 alloc_en_i,
  input logic [MEM_TAG_W-1:0] alloc_tag_i,
  input logic                 free_en_i,
  input logic [MEM_TAG_W-1:0] free_tag_i,
  input logic [NUM_TAGS-1:0]  valid_i
);
  // Reusing a tag is legal only when that same tag retires in the same cycle.
  a_no_tag_overwrite: assert property (@(posedge clock) disable iff (!reset)
    !(alloc_en_i && valid_i[alloc_tag_i] && !(free_en_i && (free_tag_i == alloc_tag_i))));
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter onto one tagged memory port, zero added latency.
// Macro MEM_ARB_STARVE_GUARD_EN enables the icache starvation guard; TEST_MODE exposes the tag table.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           proc2Imem_command,
  input  logic [XLEN-1:0]      proc2Imem_addr,
  input  logic [1:0]           proc2Dmem_command,
  input  logic [XLEN-1:0]      proc2Dmem_addr,
  input  logic [63:0]          proc2Dmem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output logic [MEM_TAG_W-1:0] Imem2proc_response,
  output logic [63:0]          Imem2proc_data,
  output logic [MEM_TAG_W-1:0] Imem2proc_tag,
  output logic [MEM_TAG_W-1:0] Dmem2proc_response,
  output logic [63:0]          Dmem2proc_data,
  output logic [MEM_TAG_W-1:0] Dmem2proc_tag,
  output logic [1:0]           proc2mem_command,
  output logic [XLEN-1:0]      proc2mem_addr,
  output logic [63:0]          proc2mem_data
`ifdef TEST_MODE
  ,
  output logic [NUM_TAGS-1:0]  show_tag_valid,
  output logic [NUM_TAGS-1:0]  show_tag_owner
`endif
);
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic     i_act_s, d_act_s, i_win_s, d_win_s, starved_s;
  logic     alloc_en_s, hit_s;
  ARB_OWNER hit_owner_s;

  assign i_act_s = (proc2Imem_command != BUS_NONE);
  assign d_act_s = (proc2Dmem_command != BUS_NONE);
  assign i_win_s = i_act_s && (!d_act_s || starved_s);
  assign d_win_s = d_act_s && !i_win_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign starved_s = (starve_q == CNT_W'(STARVE_LIMIT));

  // Count dcache wins that overtake a waiting icache; an icache win or idle icache clears it.
  always_comb begin
    starve_d = starve_q;
    if (!i_act_s || i_win_s) begin
      starve_d = {CNT_W{1'b0}};
    end else if (d_win_s && !starved_s) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= {CNT_W{1'b0}};
    else        starve_q <= starve_d;
  end
`else
  assign starved_s = 1'b0;
`endif

  // Winner drives the shared bus and alone sees the memory's acceptance tag.
  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = {XLEN{1'b0}};
    proc2mem_data      = 64'd0;
    Imem2proc_response = MEM_TAG_W'(0);
    Dmem2proc_response = MEM_TAG_W'(0);
    if (d_win_s) begin
      proc2mem_command   = proc2Dmem_command;
      proc2mem_addr      = proc2Dmem_addr;
      proc2mem_data      = proc2Dmem_data;
      Dmem2proc_response = mem2proc_response;
    end else if (i_win_s) begin
      proc2mem_command   = proc2Imem_command;
      proc2mem_addr      = proc2Imem_addr;
      Imem2proc_response = mem2proc_response;
    end else begin
      proc2mem_command   = BUS_NONE;
    end
  end

  // Only accepted loads expect data back; stores are fire-and-forget.
  assign alloc_en_s = (proc2mem_command == BUS_LOAD) && (mem2proc_response != MEM_TAG_W'(0));

  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
    .clock          (clock),
    .reset          (reset),
    .alloc_en_i     (alloc_en_s),
    .alloc_tag_i    (mem2proc_response),
    .alloc_owner_i  (d_win_s ? ARB_DCACHE : ARB_ICACHE),
    .lookup_tag_i   (mem2proc_tag),
    .lookup_hit_o   (hit_s),
    .lookup_owner_o (hit_owner_s)
`ifdef TEST_MODE
    ,
    .show_valid_o   (show_tag_valid),
    .show_owner_o   (show_tag_owner)
`endif
  );

  // Return routing: a known tag goes to its owner, unknown tags go nowhere.
  always_comb begin
    Imem2proc_tag = MEM_TAG_W'(0);
    Dmem2proc_tag = MEM_TAG_W'(0);
    if (hit_s) begin
      if (hit_owner_s == ARB_DCACHE) Dmem2proc_tag = mem2proc_tag;
      else                           Imem2proc_tag = mem2proc_tag;
    end else begin
      Imem2proc_tag = MEM_TAG_W'(0);
    end
  end

  assign Imem2proc_data = mem2proc_data;
  assign Dmem2proc_data = mem2proc_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-cycle reference model (outstanding-tag map keyed by tag).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  proc2Imem_command = 2'd0, proc2Dmem_command = 2'd0;
  logic [31:0] proc2Imem_addr = 32'd0, proc2Dmem_addr = 32'd0;
  logic [63:0] proc2Dmem_data = 64'd0, mem2proc_data = 64'd0;
  logic [3:0]  mem2proc_response = 4'd0, mem2proc_tag = 4'd0;
  logic [3:0]  Imem2proc_response, Imem2proc_tag, Dmem2proc_response, Dmem2proc_tag;
  logic [63:0] Imem2proc_data, Dmem2proc_data, proc2mem_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
`ifdef TEST_MODE
  logic [15:0] show_tag_valid, show_tag_owner;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.STARVE_LIMIT(LIM), .NUM_TAGS(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_data     (Dmem2proc_data),
    .Dmem2proc_tag      (Dmem2proc_tag),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data)
`ifdef TEST_MODE
    ,
    .show_tag_valid     (show_tag_valid),
    .show_tag_owner     (show_tag_owner)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, return 3 time units later.
  task automatic drive(input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [3:0] rsp, input logic [3:0] rtag, input logic [63:0] rdata);
    @(negedge clock);
    proc2Imem_command = ic;  proc2Imem_addr = ia;
    proc2Dmem_command = dc;  proc2Dmem_addr = da;  proc2Dmem_data = dd;
    mem2proc_response = rsp; mem2proc_tag = rtag;  mem2proc_data = rdata;
    #3;
  endtask

  task automatic idle(input logic [3:0] rtag, input logic [63:0] rdata);
    drive(BUS_NONE, 32'd0, BUS_NONE, 32'd0, 64'd0, 4'd0, rtag, rdata);
  endtask

  task automatic set_reset(input logic v);
    @(negedge clock);
    reset = v;
    #3;
  endtask

  // Reference model: outstanding loads as tag -> owner map, plus count of icache-overtaking dcache wins.
  initial begin : model
    string       owner_of [int];
    int          overtaken;
    logic        i_act, d_act, i_win, d_win, hit;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    logic [3:0]  e_iresp, e_dresp, e_itag, e_dtag;
    overtaken = 0;
    forever begin
      @(negedge clock);
      #4;
      if (!reset) begin
        owner_of.delete();
        overtaken = 0;
      end
      i_act = (proc2Imem_command != 2'd0);
      d_act = (proc2Dmem_command != 2'd0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      i_win = i_act && (!d_act || overtaken == LIM);
`else
      i_win = i_act && !d_act;
`endif
      d_win = d_act && !i_win;
      e_cmd = 2'd0; e_addr = 32'd0; e_data = 64'd0; e_iresp = 4'd0; e_dresp = 4'd0;
      if (d_win) begin
        e_cmd = proc2Dmem_command; e_addr = proc2Dmem_addr; e_data = proc2Dmem_data;
        e_dresp = mem2proc_response;
      end
      if (i_win) begin
        e_cmd = proc2Imem_command; e_addr = proc2Imem_addr; e_iresp = mem2proc_response;
      end
      hit = (mem2proc_tag != 4'd0) && owner_of.exists(int'(mem2proc_tag));
      e_itag = (hit && owner_of[int'(mem2proc_tag)] == "I") ? mem2proc_tag : 4'd0;
      e_dtag = (hit && owner_of[int'(mem2proc_tag)] == "D") ? mem2proc_tag : 4'd0;

      chk("m_cmd",   proc2mem_command,   e_cmd);
      chk("m_addr",  proc2mem_addr,      e_addr);
      chk("m_data",  proc2mem_data,      e_data);
      chk("m_iresp", Imem2proc_response, e_iresp);
      chk("m_dresp", Dmem2proc_response, e_dresp);
      chk("m_itag",  Imem2proc_tag,      e_itag);
      chk("m_dtag",  Dmem2proc_tag,      e_dtag);
      chk("m_idata", Imem2proc_data,     mem2proc_data);
      chk("m_ddata", Dmem2proc_data,     mem2proc_data);

      if (reset) begin
        if (hit) owner_of.delete(int'(mem2proc_tag));
        if (e_cmd == 2'd1 && mem2proc_response != 4'd0)
          owner_of[int'(mem2proc_response)] = d_win ? "D" : "I";
        if (!i_act || i_win)             overtaken = 0;
        else if (d_win && overtaken < LIM) overtaken++;
      end
    end
  end

  initial begin : stim
    logic [3:0] tag, prev;
    // Reset with a stray return on the bus: nothing routed, bus idle.
    mem2proc_tag = 4'd4; mem2proc_data = 64'h44;
    repeat (2) @(negedge clock);
    #3;
    chk("rst_itag", Imem2proc_tag, 64'd0);
    chk("rst_dtag", Dmem2proc_tag, 64'd0);
    chk("rst_cmd",  proc2mem_command, 64'd0);
    chk("rst_addr", proc2mem_addr, 64'd0);
    set_reset(1'b1);
    idle(4'd0, 64'd0);

    // Dcache load accepted with tag 3, returned later.
    drive(BUS_NONE, 32'd0, BUS_LOAD, 32'h10, 64'd0, 4'd3, 4'd0, 64'd0);
    chk("l_dresp", Dmem2proc_response, 64'd3);
    chk("l_iresp", Imem2proc_response, 64'd0);
    chk("l_addr",  proc2mem_addr, 64'h10);
    chk("l_cmd",   proc2mem_command, 64'd1);
    idle(4'd3, 64'hCAFE_F00D);
    chk("l_dtag",  Dmem2proc_tag, 64'd3);
    chk("l_itag",  Imem2proc_tag, 64'd0);
    chk("l_ddata", Dmem2proc_data, 64'hCAFE_F00D);

    // Store accepted with tag 5 allocates nothing; stray tag 5 goes nowhere.
    drive(BUS_NONE, 32'd0, BUS_STORE, 32'h810, 64'h1234_5678_9ABC_DEF0, 4'd5, 4'd0, 64'd0);
    chk("s_dresp", Dmem2proc_response, 64'd5);
    chk("s_cmd",   proc2mem_command, 64'd2);
    chk("s_data",  proc2mem_data, 64'h1234_5678_9ABC_DEF0);
    idle(4'd5, 64'h55);
    chk("s_itag",  Imem2proc_tag, 64'd0);
    chk("s_dtag",  Dmem2proc_tag, 64'd0);

    // Tag 2 returns to icache in the same cycle dcache is granted tag 2.
    drive(BUS_LOAD, 32'h40, BUS_NONE, 32'd0, 64'd0, 4'd2, 4'd0, 64'd0);
    chk("r_iresp", Imem2proc_response, 64'd2);
    chk("r_iaddr", proc2mem_addr, 64'h40);
    drive(BUS_NONE, 32'd0, BUS_LOAD, 32'h80, 64'd0, 4'd2, 4'd2, 64'hAA);
    chk("r_itag",  Imem2proc_tag, 64'd2);
    chk("r_dtag",  Dmem2proc_tag, 64'd0);
    chk("r_dresp", Dmem2proc_response, 64'd2);
    idle(4'd2, 64'hBB);
    chk("r_dtag2", Dmem2proc_tag, 64'd2);
    chk("r_itag2", Imem2proc_tag, 64'd0);

    // Both request with no acceptance: dcache holds the bus, icache sees 0.
    drive(BUS_LOAD, 32'h44, BUS_LOAD, 32'h88, 64'd0, 4'd0, 4'd0, 64'd0);
    chk("b_addr",  proc2mem_addr, 64'h88);
    chk("b_iresp", Imem2proc_response, 64'd0);
    idle(4'd0, 64'd0);

    // Reset with tags 1 and 4 outstanding: their returns route nowhere.
    drive(BUS_LOAD, 32'h100, BUS_NONE, 32'd0, 64'd0, 4'd1, 4'd0, 64'd0);
    drive(BUS_NONE, 32'd0, BUS_LOAD, 32'h200, 64'd0, 4'd4, 4'd0, 64'd0);
    idle(4'd0, 64'd0);
    set_reset(1'b0);
    set_reset(1'b1);
    idle(4'd1, 64'h11);
    chk("x_itag1", Imem2proc_tag, 64'd0);
    chk("x_dtag1", Dmem2proc_tag, 64'd0);
    idle(4'd4, 64'h44);
    chk("x_itag4", Imem2proc_tag, 64'd0);
    chk("x_dtag4", Dmem2proc_tag, 64'd0);

    // Both load every cycle for 20 cycles; tags 6/7 alternate, each returned the next cycle.
    idle(4'd0, 64'd0);
    for (int k = 0; k < 20; k++) begin
      tag  = (k % 2 == 1) ? 4'd7 : 4'd6;
      prev = (k == 0) ? 4'd0 : ((k % 2 == 1) ? 4'd6 : 4'd7);
      drive(BUS_LOAD, 32'h300 + 32'(k), BUS_LOAD, 32'h400 + 32'(k), 64'(k), tag, prev, 64'h7000 + 64'(k));
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (k % 5 == 4) begin
        chk("g_iresp", Imem2proc_response, 64'(tag));
        chk("g_dresp", Dmem2proc_response, 64'd0);
      end else begin
        chk("g_dresp", Dmem2proc_response, 64'(tag));
        chk("g_iresp", Imem2proc_response, 64'd0);
      end
`else
      chk("p_iresp", Imem2proc_response, 64'd0);
      chk("p_dresp", Dmem2proc_response, 64'(tag));
`endif
    end
    idle(4'd7, 64'h77);
    repeat (2) idle(4'd0, 64'd0);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive dcache grants allowed while icache waits.
REQ-002 Parameter NUM_TAGS, default 16: memory tag space; tag 0 means "no response".
REQ-003 clock  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 proc2Imem_command/addr  input  2/XLEN  icache request (BUS_NONE/BUS_LOAD only).
REQ-006 proc2Dmem_command/addr/data  input  2/XLEN/64  dcache request (BUS_NONE/BUS_LOAD/BUS_STORE).
REQ-007 Imem2proc_response, Dmem2proc_response  output  4 each  acceptance tag to each requester; 0 = not accepted, retry.
REQ-008 Imem2proc_data/tag, Dmem2proc_data/tag  output  64/4 each  routed memory return data and tag.
REQ-009 proc2mem_command/addr/data  output  2/XLEN/64  to shared memory.
REQ-010 mem2proc_response/data/tag  input  4/64/4  from shared memory.

Function
REQ-011 Request decode: a requester is active when its command != BUS_NONE.
REQ-012 Grant: dcache only active -> dcache; icache only active -> icache; both -> dcache unless starve_cnt == STARVE_LIMIT, then icache.
REQ-013 Winner's command/addr/data drive proc2mem_* combinationally in the same cycle; no winner -> BUS_NONE, addr 0, data 0.
REQ-014 mem2proc_response goes to the winner's *_response only; loser and idle requester see 0 in that cycle.
REQ-015 starve_cnt (saturating, width clog2(STARVE_LIMIT+1)): +1 on a dcache grant while icache is active; cleared on any icache grant or a cycle with icache idle.
REQ-016 Store acceptances (nonzero response to a BUS_STORE) allocate no tag-table entry.
REQ-017 Load acceptance with tag T: on posedge, owner[T] <= winner, valid[T] <= 1.
REQ-018 Return routing: mem2proc_tag T != 0 with valid[T] -> owner's *_tag = T and *_data = mem2proc_data; other requester's tag = 0; valid[T] cleared on posedge.
REQ-019 Return of a tag with valid[T] == 0 (e.g. reset mid-transaction): both *_tag = 0, no state change.
REQ-020 *_data outputs equal mem2proc_data at all times; consumers qualify on *_tag.
REQ-021 Same cycle return of T and new acceptance of T: lookup uses pre-edge table, allocation wins, valid[T] = 1 after edge.
REQ-022 Acceptance with a tag already valid (memory protocol violation): overwrite owner; flag via assertion in simulation.
REQ-023 Zero added latency: every output is a combinational function of inputs and registered state.

Reset
REQ-024 reset low: all valid[] = 0, owner[] = 0, starve_cnt = 0 asynchronously.
REQ-025 During reset all outputs are driven by combinational rules on the cleared state; a response arriving during reset is routed nowhere.

Configuration
REQ-026 Macro MEM_ARB_STARVE_GUARD_EN defined: REQ-012/015 starvation guard active.
REQ-027 Macro undefined: strict dcache priority, starve_cnt not instantiated, STARVE_LIMIT ignored.

Structure
REQ-028 BUS_COMMAND enum, MEM_TAG_W (4) and the ARB_OWNER enum (ARB_ICACHE, ARB_DCACHE) reside in sys_defs.svh.
REQ-029 Sub-module mem_tag_table holds owner/valid arrays with one allocate port and one lookup/free port.
REQ-030 TEST_MODE exposes show_tag_table (valid/owner per tag) as in other memory-side blocks.

Verification
REQ-031 Dcache LOAD 0x10 only, mem accepts tag 3 -> Dmem2proc_response = 3, Imem2proc_response = 0; later tag 3 returns -> Dmem2proc_tag = 3, Imem2proc_tag = 0.
REQ-032 Both LOAD each cycle, guard on, STARVE_LIMIT = 4 -> four dcache grants, fifth cycle icache granted, counter back to 0.
REQ-033 Dcache STORE 0x810 accepted tag 5 -> no table entry; stray tag-5 return routes to neither requester.
REQ-034 Icache load tag 2 returns in same cycle dcache load is accepted with tag 2 -> Imem2proc_tag = 2 that cycle; next return of tag 2 goes to dcache.
REQ-035 Reset asserted with tags 1, 4 outstanding, then released; tags 1, 4 return -> both *_tag = 0, table all invalid.
REQ-036 Guard undefined, both requesting for 20 cycles -> icache never granted, Imem2proc_response = 0 throughout.
